// File: rtl/picorv32_sram_pkg.sv
// picorv32_sram_pkg: shared SRAM geometry, channel FSM states and bank/row address decode
package picorv32_sram_pkg;
    localparam int SRAM_WORDS = 512;
    localparam int SRAM_AW = 9;
    localparam int SRAM_DW = 32;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef struct packed {
        logic ok;
        logic [2:0] bank;
        logic [SRAM_AW-1:0] row;
    } dec_t;
    function automatic dec_t decode(input logic [31:0] addr, input logic [31:0] base, input int nbanks);
        logic [31:0] word;
        dec_t d;
        word = (addr - base) >> 2;
        d.ok = addr >= base && word < 32'(nbanks * SRAM_WORDS);
        d.bank = word[11:9];
        d.row = word[8:0];
        return d;
    endfunction
endpackage

// File: rtl/sram_chan_fsm.sv
// sram_chan_fsm: one SRAM port sequencer (decode, chip select, read latency, ready/err pulses)
module sram_chan_fsm import picorv32_sram_pkg::*; #(
    parameter int NUM_BANKS = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int SRAM_LAT = 1,
    parameter bit WRITE_EN = 1'b1
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         valid,
    input  logic [31:0]                  addr,
    input  logic [31:0]                  wdata,
    input  logic [3:0]                   wstrb,
    output logic                         ready,
    output logic [SRAM_DW-1:0]           rdata,
    output logic                         err,
    output logic                         bad,
    output logic [NUM_BANKS-1:0]         csb,
    output logic                         web,
    output logic [3:0]                   wmask,
    output logic [SRAM_AW-1:0]           sram_addr,
    output logic [SRAM_DW-1:0]           din,
    input  logic [SRAM_DW*NUM_BANKS-1:0] dout
);
    state_t state;
    dec_t dec;
    logic [2:0] bank;
    logic [1:0] cnt;
    logic wr, is_wr;
    logic [NUM_BANKS-1:0] sel;
    logic [SRAM_DW-1:0] dout_sel;

    assign dec = decode(addr, BASE_ADDR, NUM_BANKS);
    assign is_wr = WRITE_EN && wstrb != 4'b0;
    assign bad = state == IDLE && valid && !dec.ok;

    always_comb begin
        sel = '1;
        dout_sel = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (dec.bank == 3'(b)) sel[b] = 1'b0;
            if (bank == 3'(b)) dout_sel = dout[SRAM_DW*b +: SRAM_DW];
        end
    end

    // csb/web/wmask default to idle every edge so they are only active for the ISSUE cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            bank <= '0;
            wr <= 1'b0;
            cnt <= '0;
            ready <= 1'b0;
            err <= 1'b0;
            rdata <= '0;
            csb <= '1;
            web <= 1'b1;
            wmask <= '0;
            sram_addr <= '0;
            din <= '0;
        end else begin
            ready <= 1'b0;
            err <= 1'b0;
            csb <= '1;
            web <= 1'b1;
            wmask <= '0;
            case (state)
                IDLE: if (valid) begin
                    if (dec.ok) begin
                        state <= ISSUE;
                        bank <= dec.bank;
                        wr <= is_wr;
                        csb <= sel;
                        web <= !is_wr;
                        wmask <= is_wr ? wstrb : 4'b0;
                        sram_addr <= dec.row;
                        din <= wdata;
                    end else begin
                        state <= RESP;
                        ready <= 1'b1;
                        err <= 1'b1;
                        rdata <= '0;
                    end
                end
                ISSUE: begin
                    state <= wr ? RESP : WAIT;
                    ready <= wr;
                    cnt <= 2'(SRAM_LAT);
                end
                WAIT: begin
                    cnt <= cnt - 2'd1;
                    if (cnt == 2'd1) begin
                        rdata <= dout_sel;
                        ready <= 1'b1;
                        state <= RESP;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/picorv32_sram_bridge.sv
// picorv32_sram_bridge: picorv32 native bus (port 0) and debug read channel (port 1) onto
// NUM_BANKS sky130 1rw1r SRAM macros, with sticky first-error address capture.
module picorv32_sram_bridge import picorv32_sram_pkg::*; #(
    parameter int NUM_BANKS = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int SRAM_LAT = 1
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         mem_valid,
    input  logic [31:0]                  mem_addr,
    input  logic [31:0]                  mem_wdata,
    input  logic [3:0]                   mem_wstrb,
    output logic                         mem_ready,
    output logic [31:0]                  mem_rdata,
    input  logic                         dbg_valid,
    input  logic [31:0]                  dbg_addr,
    output logic                         dbg_ready,
    output logic [31:0]                  dbg_rdata,
    output logic                         err,
    output logic [31:0]                  err_addr,
    output logic [NUM_BANKS-1:0]         sram_csb0,
    output logic                         sram_web0,
    output logic [3:0]                   sram_wmask0,
    output logic [SRAM_AW-1:0]           sram_addr0,
    output logic [SRAM_DW-1:0]           sram_din0,
    input  logic [SRAM_DW*NUM_BANKS-1:0] sram_dout0,
    output logic [NUM_BANKS-1:0]         sram_csb1,
    output logic [SRAM_AW-1:0]           sram_addr1,
    input  logic [SRAM_DW*NUM_BANKS-1:0] sram_dout1
);
    logic err0, err1, bad0, bad1, err_seen;
    logic p1_unused_web;
    logic [3:0] p1_unused_wmask;
    logic [SRAM_DW-1:0] p1_unused_din;

    sram_chan_fsm #(.NUM_BANKS(NUM_BANKS), .BASE_ADDR(BASE_ADDR), .SRAM_LAT(SRAM_LAT), .WRITE_EN(1'b1)) u_port0 (
        .clk(clk), .resetn(resetn), .valid(mem_valid), .addr(mem_addr), .wdata(mem_wdata), .wstrb(mem_wstrb),
        .ready(mem_ready), .rdata(mem_rdata), .err(err0), .bad(bad0), .csb(sram_csb0), .web(sram_web0),
        .wmask(sram_wmask0), .sram_addr(sram_addr0), .din(sram_din0), .dout(sram_dout0)
    );

    sram_chan_fsm #(.NUM_BANKS(NUM_BANKS), .BASE_ADDR(BASE_ADDR), .SRAM_LAT(SRAM_LAT), .WRITE_EN(1'b0)) u_port1 (
        .clk(clk), .resetn(resetn), .valid(dbg_valid), .addr(dbg_addr), .wdata(32'h0), .wstrb(4'h0),
        .ready(dbg_ready), .rdata(dbg_rdata), .err(err1), .bad(bad1), .csb(sram_csb1), .web(p1_unused_web),
        .wmask(p1_unused_wmask), .sram_addr(sram_addr1), .din(p1_unused_din), .dout(sram_dout1)
    );

    assign err = err0 | err1;

    // Port 0 takes priority when both channels fault on the same edge
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_seen <= 1'b0;
            err_addr <= '0;
        end else if (!err_seen && (bad0 || bad1)) begin
            err_seen <= 1'b1;
            err_addr <= bad0 ? mem_addr : dbg_addr;
        end
    end
endmodule
